// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a NUM_DIGITS-digit common-anode
//   7-segment display. It feeds one digit's nibble at a time to a shared
//   BCD-to-7seg decoder and drives the active-low anode enables. All anodes
//   stay off for BLANK_CYCLES at the start of every slot, which hides the
//   decoder latency and ghosting. New values are double-buffered and only
//   committed at frame boundaries, so a frame never shows a mix of old and
//   new digits. Leading zeros can optionally be blanked.
//
// Ports
//   clk         in   1             system clock, posedge
//   rst_n       in   1             synchronous reset, active-low
//   bcd_in      in   4*NUM_DIGITS  new value, nibble i = digit i (digit 0 = LS)
//   load        in   1             1-cycle strobe: capture bcd_in
//   lz_en       in   1             1 = blank leading zeros
//   dec_nibble  out  4             decoder input, 4'hF = blank code
//   an          out  NUM_DIGITS    anode enables, active-low, at most one low
//   frame_tick  out  1             1-cycle pulse after a frame completes
//   pend        out  1             a loaded value waits for the frame boundary
//
// Handshake: load is a plain strobe with no ready. Every asserted cycle is
// accepted; the last load before a frame boundary is the one displayed.
//
// Outputs are registered from the counter state of the previous cycle, so
// the visible scan lags the internal counters by one cycle. That edge is
// also where dec_nibble changes, so the decoder has settled before the
// anode turns on.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      load,
    input  logic                      lz_en,
    output logic [3:0]                dec_nibble,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick,
    output logic                      pend
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Per-slot phase
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [CW-1:0]           slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DW-1:0]           display_q, display_d;
    logic [DW-1:0]           pending_q, pending_d;
    logic                    pend_q, pend_d;
    logic [3:0]              dec_nibble_q, dec_nibble_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q, frame_tick_d;

    logic [0:0]              phase;
    logic                    slot_wrap, frame_end;
    logic [3:0]              digit [NUM_DIGITS];
    logic                    zero_from [NUM_DIGITS];
    logic                    zero_above;
    logic [3:0]              cur_nib;

    // zero_from[i]: digits i..N-1 of the committed value are all zero.
    always_comb begin
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            digit[i]     = display_q[4*i +: 4];
            zero_from[i] = zero_above && (digit[i] == 4'd0);
            zero_above   = zero_from[i];
        end
        cur_nib = digit[idx_q];
        // Digit 0 is never blanked so a zero value still shows "0".
        if (lz_en && (idx_q != '0) && zero_from[idx_q]) begin
            cur_nib = 4'hF;
        end
    end

    always_comb begin
        slot_wrap = (slot_cnt_q == SLOT_LAST);
        frame_end = slot_wrap && (idx_q == IDX_LAST);
        phase     = (slot_cnt_q < BLANK_END) ? ST_BLANK : ST_SHOW;

        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        pending_d = load ? bcd_in : pending_q;
        pend_d    = pend_q;
        display_d = display_q;
        if (frame_end) begin
            // A load on the boundary cycle is newer than anything pending.
            if (load) begin
                display_d = bcd_in;
            end else if (pend_q) begin
                display_d = pending_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            pend_d = 1'b1;
        end

        an_d = '1;
        if (phase == ST_SHOW) begin
            an_d[idx_q] = 1'b0;
        end

        // Latch the nibble (and lz_en) once per slot at its first cycle.
        dec_nibble_d = (slot_cnt_q == '0) ? cur_nib : dec_nibble_q;
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            idx_q        <= '0;
            display_q    <= '0;
            pending_q    <= '0;
            pend_q       <= 1'b0;
            dec_nibble_q <= 4'hF;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            pend_q       <= pend_d;
            dec_nibble_q <= dec_nibble_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign dec_nibble = dec_nibble_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
    assign pend       = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
    localparam int N  = 4;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int FR = N * R;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   bcd_in;
    logic          load;
    logic          lz_en;
    logic [3:0]    dec_nibble;
    logic [3:0]    an;
    logic          frame_tick;
    logic          pend;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .load       (load),
        .lz_en      (lz_en),
        .dec_nibble (dec_nibble),
        .an         (an),
        .frame_tick (frame_tick),
        .pend       (pend)
    );

    // Reference model: time since release as a plain cycle position.
    int          m_pos;
    logic [15:0] m_disp;
    logic [15:0] m_pend_val;
    logic        m_pend;
    logic [3:0]  m_dec;
    logic [3:0]  exp_an;
    logic        exp_tick;

    typedef struct {
        logic [15:0] val;
        logic        lz;
        logic [15:0] exp_nibs;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [3:0] ref_nib(input logic [15:0] v, input int i, input logic lz);
        logic [15:0] upper;
        upper = v >> (4 * i);
        if (lz && (i != 0) && (upper == 16'd0)) return 4'hF;
        return upper[3:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic        r, l, z;
        logic [15:0] b;
        int          slot, dig;
        bit          fe;
        @(posedge clk);
        r = rst_n; l = load; z = lz_en; b = bcd_in;
        if (!r) begin
            m_pos = 0; m_disp = 16'h0; m_pend = 1'b0; m_pend_val = 16'h0;
            m_dec = 4'hF; exp_an = 4'hF; exp_tick = 1'b0;
        end else begin
            slot   = m_pos % R;
            dig    = (m_pos / R) % N;
            fe     = ((m_pos % FR) == FR - 1);
            exp_an = (slot < B) ? 4'hF : (4'hF ^ (4'b1 << dig));
            if (slot == 0) m_dec = ref_nib(m_disp, dig, z);
            exp_tick = fe;
            if (fe) begin
                if (l) m_disp = b;
                else if (m_pend) m_disp = m_pend_val;
                m_pend = 1'b0;
            end else if (l) begin
                m_pend_val = b;
                m_pend     = 1'b1;
            end
            m_pos++;
        end
        #1;
        chk("an", {28'h0, an}, {28'h0, exp_an});
        chk("dec", {28'h0, dec_nibble}, {28'h0, m_dec});
        chk("tick", {31'h0, frame_tick}, {31'h0, exp_tick});
        chk("pend", {31'h0, pend}, {31'h0, m_pend});
        load = 1'b0;
    endtask

    // Steps until frame_tick is seen, bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < 2 * FR);
        if (!frame_tick) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    // Runs one whole frame right after a tick, checking each digit's SHOW phase.
    task automatic show_frame(input logic [15:0] exp_n, input string tag);
        int k;
        for (int s = 1; s <= FR; s++) begin
            step();
            if ((s - 1) % R == B) begin
                k = (s - 1) / R;
                chk({tag, "_an"}, {28'h0, an}, 32'hF ^ (32'h1 << k));
                chk({tag, "_dig"}, {28'h0, dec_nibble}, {28'h0, exp_n[4*k +: 4]});
            end
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h1234, 1'b0, 16'h1234};
        vecs[1] = '{16'h0070, 1'b1, 16'hFF70};
        vecs[2] = '{16'h0000, 1'b1, 16'hFFF0};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000};
        vecs[4] = '{16'hABCD, 1'b0, 16'hABCD};
        vecs[5] = '{16'h0102, 1'b1, 16'hF102};
        vecs[6] = '{16'h9000, 1'b1, 16'h9000};
        vecs[7] = '{16'h0070, 1'b0, 16'h0070};

        // Reset held 3 cycles
        rst_n = 1'b0; load = 1'b0; bcd_in = 16'h0; lz_en = 1'b0;
        repeat (3) step();
        chk("rst_an", {28'h0, an}, 32'hF);
        chk("rst_dec", {28'h0, dec_nibble}, 32'hF);
        chk("rst_tick", {31'h0, frame_tick}, 32'd0);
        chk("rst_pend", {31'h0, pend}, 32'd0);
        rst_n = 1'b1;

        wait_tick(n);
        chk("first_tick_gap", n, 32'd32);
        wait_tick(n);
        chk("tick_period", n, 32'd32);

        // Table-driven values: load at frame start, shown after next boundary
        foreach (vecs[i]) begin
            lz_en  = vecs[i].lz;
            bcd_in = vecs[i].val;
            load   = 1'b1;
            step();
            chk("pend_after_load", {31'h0, pend}, 32'd1);
            wait_tick(n);
            chk("load_wait", n, 32'd31);
            chk("pend_cleared", {31'h0, pend}, 32'd0);
            show_frame(vecs[i].exp_nibs, "vec");
        end

        // Load on the frame-end cycle goes straight to the display
        lz_en = 1'b0;
        repeat (FR - 1) step();
        bcd_in = 16'h2468;
        load   = 1'b1;
        step();
        chk("fe_tick", {31'h0, frame_tick}, 32'd1);
        chk("fe_pend", {31'h0, pend}, 32'd0);
        show_frame(16'h2468, "fe_load");

        // Two loads in mid-frame: display unchanged until boundary, last wins
        repeat (10) step();
        bcd_in = 16'h1111; load = 1'b1;
        step();
        chk("mid_pend", {31'h0, pend}, 32'd1);
        repeat (3) step();
        bcd_in = 16'h5678; load = 1'b1;
        step();
        wait_tick(n);
        chk("mid_wait", n, 32'd17);
        show_frame(16'h5678, "last_wins");

        // Reset in slot 2 discards the pending value
        bcd_in = 16'h9999; load = 1'b1;
        step();
        repeat (17) step();
        rst_n = 1'b0;
        step();
        chk("mrst_an", {28'h0, an}, 32'hF);
        chk("mrst_dec", {28'h0, dec_nibble}, 32'hF);
        chk("mrst_pend", {31'h0, pend}, 32'd0);
        chk("mrst_tick", {31'h0, frame_tick}, 32'd0);
        rst_n = 1'b1;
        wait_tick(n);
        chk("mrst_restart", n, 32'd32);
        show_frame(16'h0000, "mrst_zero");

        // Random loads and lz_en changes against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                bcd_in = 16'($urandom);
                load   = 1'b1;
            end
            if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
